// File: rtl/route_decoder_pkg.sv
// Shared types and helpers for route_decoder: FSM encoding, stats counter width,
// leading-ones count of the level mask and the out0/out1 route decision.
package route_decoder_pkg;

  localparam int STATS_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Number of consecutive ones counted down from bit width-1.
  function automatic int lead_ones(input logic [31:0] mask, input int width);
    int n;
    logic run;
    logic [31:0] sh;
    n   = 0;
    run = 1'b1;
    for (int i = width - 1; i >= 0; i--) begin
      sh = mask >> i;
      if (run && sh[0]) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  // Returns 0 for out0 and 1 for out1. A full mask leaves no tree bit, so it
  // falls back to the exact leaf compare.
  function automatic logic route_sel(input logic [31:0] a, input logic [31:0] node_addr,
                                     input logic [31:0] node_mask, input int width,
                                     input bit leaf);
    int k;
    logic [31:0] sh;
    k = lead_ones(node_mask, width);
    if (leaf || k >= width) begin
      return ((a & node_mask) != node_addr);
    end
    sh = a >> (width - 1 - k);
    return sh[0];
  endfunction

endpackage

// File: rtl/route_token_reg.sv
// One registered output token: loads on request, holds data/valid stable
// until the consumer takes it.
module route_token_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] data,
  output logic         valid,
  input  logic         ready,
  output logic         free
);

  logic [W-1:0] data_reg, data_next;
  logic         valid_reg, valid_next;

  always_comb begin
    data_next  = data_reg;
    valid_next = valid_reg;
    if (load) begin
      data_next  = load_data;
      valid_next = 1'b1;
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  // Slot is empty by the end of this cycle unless reloaded.
  assign free  = !valid_reg || ready;

endmodule

// File: rtl/route_decoder.sv
// Single-flit route decoder: steers each flit to out0 or out1 and emits a sel token.
// Optional per-output acceptance counters when ROUTE_DECODER_STATS_EN is defined.
module route_decoder
  import route_decoder_pkg::*;
#(
  parameter int                DATA_W    = 9,
  parameter int                ADDR_W    = 4,
  parameter int                ADDR_LSB  = 5,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 4'b1010,
  parameter logic [ADDR_W-1:0] NODE_MASK = 4'b1110,
  parameter int                LEAF      = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              sel,
  output logic              sel_valid,
`ifdef ROUTE_DECODER_STATS_EN
  input  logic              sel_ready,
  output logic [STATS_W-1:0] out0_cnt,
  output logic [STATS_W-1:0] out1_cnt
`else
  input  logic              sel_ready
`endif
);

  state_t            state_reg, state_next;
  logic              live_reg;
  logic              accept, route, sel_free, all_free;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] out_data [2];
  logic [1:0]        out_valid, out_ready, out_load, out_free;

  assign addr     = in_data[ADDR_LSB+ADDR_W-1:ADDR_LSB];
  assign route    = route_sel(32'(addr), 32'(NODE_ADDR), 32'(NODE_MASK), ADDR_W, LEAF != 0);
  assign accept   = in_valid && in_ready;
  assign all_free = sel_free && (&out_free);

  // Held low through reset and released on the first edge afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_reg <= 1'b0;
    else        live_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (!accept && all_free) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      ST_EMPTY: in_ready = live_reg;
      ST_FULL:  in_ready = live_reg && all_free;
      default:  in_ready = 1'b0;
    endcase
  end

  route_token_reg #(.W(1)) u_sel_tok (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (route),
    .data      (sel),
    .valid     (sel_valid),
    .ready     (sel_ready),
    .free      (sel_free)
  );

  assign out_ready = {out1_ready, out0_ready};
  assign out_load  = {accept && route, accept && !route};

  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    route_token_reg #(.W(DATA_W)) u_out_tok (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (out_load[gi]),
      .load_data (in_data),
      .data      (out_data[gi]),
      .valid     (out_valid[gi]),
      .ready     (out_ready[gi]),
      .free      (out_free[gi])
    );
  end

  assign out0_data  = out_data[0];
  assign out1_data  = out_data[1];
  assign out0_valid = out_valid[0];
  assign out1_valid = out_valid[1];

`ifdef ROUTE_DECODER_STATS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [STATS_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (out_valid[gi] && out_ready[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign out0_cnt = g_cnt[0].cnt_reg;
  assign out1_cnt = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_route_decoder.sv
// Scoreboard bench for route_decoder: tree-mode instance under directed and random
// traffic, plus leaf-mode and full-mask instances checked per flit.
module tb_route_decoder;

  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Tree instance (LEAF=0, NODE_MASK=4'b1100)
  logic [DW-1:0] t_in_data, t_out0_data, t_out1_data;
  logic t_in_valid, t_in_ready, t_out0_valid, t_out0_ready, t_out1_valid, t_out1_ready;
  logic t_sel, t_sel_valid, t_sel_ready;

  // Leaf instance (LEAF=1) and full-mask tree instance share the input side
  logic [DW-1:0] l_in_data, lf_out0_data, lf_out1_data, fu_out0_data, fu_out1_data;
  logic l_in_valid, lf_in_ready, fu_in_ready;
  logic lf_out0_valid, lf_out1_valid, lf_sel, lf_sel_valid;
  logic fu_out0_valid, fu_out1_valid, fu_sel, fu_sel_valid;

`ifdef ROUTE_DECODER_STATS_EN
  logic [15:0] t_out0_cnt, t_out1_cnt, lf_out0_cnt, lf_out1_cnt, fu_out0_cnt, fu_out1_cnt;
`endif

  route_decoder #(.LEAF(0), .NODE_MASK(4'b1100), .NODE_ADDR(4'b1000)) u_tree (
    .clk(clk), .rst_n(rst_n),
    .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .out0_data(t_out0_data), .out0_valid(t_out0_valid), .out0_ready(t_out0_ready),
    .out1_data(t_out1_data), .out1_valid(t_out1_valid), .out1_ready(t_out1_ready),
    .sel(t_sel), .sel_valid(t_sel_valid),
`ifdef ROUTE_DECODER_STATS_EN
    .sel_ready(t_sel_ready), .out0_cnt(t_out0_cnt), .out1_cnt(t_out1_cnt)
`else
    .sel_ready(t_sel_ready)
`endif
  );

  route_decoder #(.LEAF(1)) u_leaf (
    .clk(clk), .rst_n(rst_n),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(lf_in_ready),
    .out0_data(lf_out0_data), .out0_valid(lf_out0_valid), .out0_ready(1'b1),
    .out1_data(lf_out1_data), .out1_valid(lf_out1_valid), .out1_ready(1'b1),
    .sel(lf_sel), .sel_valid(lf_sel_valid),
`ifdef ROUTE_DECODER_STATS_EN
    .sel_ready(1'b1), .out0_cnt(lf_out0_cnt), .out1_cnt(lf_out1_cnt)
`else
    .sel_ready(1'b1)
`endif
  );

  route_decoder #(.LEAF(0), .NODE_MASK(4'b1111)) u_full (
    .clk(clk), .rst_n(rst_n),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(fu_in_ready),
    .out0_data(fu_out0_data), .out0_valid(fu_out0_valid), .out0_ready(1'b1),
    .out1_data(fu_out1_data), .out1_valid(fu_out1_valid), .out1_ready(1'b1),
    .sel(fu_sel), .sel_valid(fu_sel_valid),
`ifdef ROUTE_DECODER_STATS_EN
    .sel_ready(1'b1), .out0_cnt(fu_out0_cnt), .out1_cnt(fu_out1_cnt)
`else
    .sel_ready(1'b1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference routing: address field is in_data / 32; tree bit sits below the k mask ones.
  function automatic logic model_route(input logic [DW-1:0] d, input int mask, input int naddr,
                                       input bit leaf);
    int a, k;
    a = int'(d) / 32;
    k = $countones(mask);
    if (leaf || k == 4) return ((a & mask) == naddr) ? 1'b0 : 1'b1;
    return ((a / (1 << (3 - k))) % 2 == 1) ? 1'b1 : 1'b0;
  endfunction

  // Scoreboard monitor for the tree instance
  logic          sel_q[$];
  logic [DW:0]   dat_q[$];
  logic          lat_pend = 1'b0;
  logic          lat_route = 1'b0;
  logic [2:0]    hold = '0;
  logic [DW-1:0] hold_dat [3];
  int            n_out [2];

  always @(negedge clk) begin : mon
    logic [2:0]    vld, rdy;
    logic [DW-1:0] dat [3];
    logic [DW:0]   tok;
    logic          s;
    vld = {t_out1_valid, t_out0_valid, t_sel_valid};
    rdy = {t_out1_ready, t_out0_ready, t_sel_ready};
    dat[0] = {{(DW-1){1'b0}}, t_sel};
    dat[1] = t_out0_data;
    dat[2] = t_out1_data;
    if (!rst_n) begin
      sel_q.delete();
      dat_q.delete();
      lat_pend = 1'b0;
      hold     = '0;
      n_out[0] = 0;
      n_out[1] = 0;
    end else begin
      if (lat_pend) begin
        chk("latency_sel_valid", 32'(t_sel_valid), 32'(1));
        chk("latency_route_valid", 32'(lat_route ? t_out1_valid : t_out0_valid), 32'(1));
      end
      for (int i = 0; i < 3; i++) begin
        if (hold[i]) begin
          chk("hold_valid", 32'(vld[i]), 32'(1));
          chk("hold_data", 32'(dat[i]), 32'(hold_dat[i]));
        end
      end
      chk("single_data_valid", 32'(t_out0_valid & t_out1_valid), 32'(0));
      if (t_sel_valid && t_sel_ready) begin
        if (sel_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sel_extra: got sel token %0d expected none", t_sel);
        end else begin
          s = sel_q.pop_front();
          chk("sel_value", 32'(t_sel), 32'(s));
        end
      end
      for (int o = 0; o < 2; o++) begin
        if (vld[o+1] && rdy[o+1]) begin
          if (dat_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL data_extra: got out%0d token %0h expected none", o, dat[o+1]);
          end else begin
            tok = dat_q.pop_front();
            chk("data_route", 32'(o), 32'(tok[DW]));
            chk("data_value", 32'(dat[o+1]), 32'(tok[DW-1:0]));
          end
          n_out[o] = (n_out[o] == 65535) ? 65535 : n_out[o] + 1;
        end
      end
      lat_pend = t_in_valid && t_in_ready;
      if (lat_pend) begin
        lat_route = model_route(t_in_data, 4'b1100, 4'b1000, 1'b0);
        sel_q.push_back(lat_route);
        dat_q.push_back({lat_route, t_in_data});
      end
      for (int i = 0; i < 3; i++) begin
        hold[i]     = vld[i] && !rdy[i];
        hold_dat[i] = dat[i];
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic r;
    rst_n = 1'b0;
    t_in_data = '0; t_in_valid = 1'b0;
    t_out0_ready = 1'b0; t_out1_ready = 1'b0; t_sel_ready = 1'b0;
    l_in_data = '0; l_in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(t_in_ready), 32'(0));
    chk("rst_sel_valid", 32'(t_sel_valid), 32'(0));
    chk("rst_out_valid", 32'({t_out1_valid, t_out0_valid}), 32'(0));
    chk("rst_sel", 32'(t_sel), 32'(0));
    chk("rst_out_data", 32'({t_out1_data, t_out0_data}), 32'(0));
    chk("rst_leaf_in_ready", 32'(lf_in_ready), 32'(0));
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(t_in_ready), 32'(0));
    @(posedge clk); #1;
    chk("ready_after_edge", 32'(t_in_ready), 32'(1));

    // Leaf and full-mask instances: the two named flits, then every address
    for (int i = 0; i < 18; i++) begin
      if (i == 0)      d = 9'b1011_00000;
      else if (i == 1) d = 9'b1100_00000;
      else             d = {4'(i - 2), 5'($urandom)};
      l_in_data = d; l_in_valid = 1'b1;
      @(negedge clk);
      chk("leaf_in_ready", 32'(lf_in_ready & fu_in_ready), 32'(1));
      @(posedge clk); #1;
      r = model_route(d, 4'b1110, 4'b1010, 1'b1);
      chk("leaf_sel", 32'(lf_sel), 32'(r));
      chk("leaf_sel_valid", 32'(lf_sel_valid), 32'(1));
      chk("leaf_valids", 32'({lf_out1_valid, lf_out0_valid}), 32'(r ? 2'b10 : 2'b01));
      chk("leaf_data", 32'(r ? lf_out1_data : lf_out0_data), 32'(d));
      r = model_route(d, 4'b1111, 4'b1010, 1'b0);
      chk("full_sel", 32'(fu_sel), 32'(r));
      chk("full_valids", 32'({fu_out1_valid, fu_out0_valid}), 32'(r ? 2'b10 : 2'b01));
      chk("full_data", 32'(r ? fu_out1_data : fu_out0_data), 32'(d));
    end
    l_in_valid = 1'b0;

    // Tree bit: a=1101 -> out0, a=1110 -> out1
    t_out0_ready = 1'b1; t_out1_ready = 1'b1; t_sel_ready = 1'b1;
    t_in_data = {4'b1101, 5'($urandom)}; t_in_valid = 1'b1;
    @(posedge clk); #1;
    t_in_data = {4'b1110, 5'($urandom)};
    chk("tree_1101_sel", 32'(t_sel), 32'(0));
    chk("tree_1101_out0", 32'(t_out0_valid), 32'(1));
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    chk("tree_1110_sel", 32'(t_sel), 32'(1));
    chk("tree_1110_out1", 32'(t_out1_valid), 32'(1));
    repeat (2) @(posedge clk); #1;

    // Eight back-to-back flits
    for (int i = 0; i < 9; i++) begin
      t_in_valid = (i < 8); t_in_data = 9'($urandom);
      @(negedge clk);
      if (i < 8) chk("b2b_in_ready", 32'(t_in_ready), 32'(1));
      if (i > 0) chk("b2b_out_valid", 32'(t_sel_valid & (t_out0_valid | t_out1_valid)), 32'(1));
      @(posedge clk); #1;
    end
    t_in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // sel held back for 3 cycles while data drains
    t_sel_ready = 1'b0;
    t_in_data = {4'b0000, 5'($urandom)}; t_in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept_a", 32'(t_in_ready), 32'(1));
    @(posedge clk); #1;
    t_in_data = {4'b0101, 5'($urandom)};
    @(negedge clk);
    chk("bp_c1_out0_valid", 32'(t_out0_valid), 32'(1));
    chk("bp_c1_sel_valid", 32'(t_sel_valid), 32'(1));
    chk("bp_c1_in_ready", 32'(t_in_ready), 32'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_out0_gone", 32'(t_out0_valid), 32'(0));
      chk("bp_sel_held", 32'(t_sel_valid), 32'(1));
      chk("bp_in_ready_low", 32'(t_in_ready), 32'(0));
      @(posedge clk); #1;
    end
    t_sel_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(t_in_ready), 32'(1));
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset with a token pending
    t_sel_ready = 1'b0; t_out0_ready = 1'b0; t_out1_ready = 1'b0;
    t_in_data = {4'($urandom), 5'b10101}; t_in_valid = 1'b1;
    @(negedge clk);
    chk("pend_accept", 32'(t_in_ready), 32'(1));
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    @(negedge clk);
    chk("pend_sel_valid", 32'(t_sel_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valids", 32'({t_sel_valid, t_out1_valid, t_out0_valid}), 32'(0));
    chk("arst_in_ready", 32'(t_in_ready), 32'(0));
    chk("arst_sel", 32'(t_sel), 32'(0));
    chk("arst_data", 32'({t_out1_data, t_out0_data}), 32'(0));
    repeat (2) @(posedge clk);
    t_sel_ready = 1'b1; t_out0_ready = 1'b1; t_out1_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_ready_before_edge", 32'(t_in_ready), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("arst_no_ghost", 32'({t_sel_valid, t_out1_valid, t_out0_valid}), 32'(0));
      chk("arst_in_ready_up", 32'(t_in_ready), 32'(1));
    end

    // Random traffic and backpressure
    repeat (600) begin
      t_in_valid   = 1'($urandom_range(0, 1));
      t_in_data    = 9'($urandom);
      t_out0_ready = ($urandom_range(0, 3) != 0);
      t_out1_ready = ($urandom_range(0, 3) != 0);
      t_sel_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    t_in_valid = 1'b0;
    t_out0_ready = 1'b1; t_out1_ready = 1'b1; t_sel_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("drain_sel_q", 32'(sel_q.size()), 32'(0));
    chk("drain_dat_q", 32'(dat_q.size()), 32'(0));

`ifdef ROUTE_DECODER_STATS_EN
    chk("stats_out0_cnt", 32'(t_out0_cnt), 32'(n_out[0]));
    chk("stats_out1_cnt", 32'(t_out1_cnt), 32'(n_out[1]));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("stats_rst_out1_cnt", 32'(t_out1_cnt), 32'(0));
    t_in_data = {4'b1110, 5'd3}; t_in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 t_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("stats_sat_out1_cnt", 32'(t_out1_cnt), 32'(16'hFFFF));
    chk("stats_sat_out0_cnt", 32'(t_out0_cnt), 32'(0));
    chk("stats_model_out1_cnt", 32'(t_out1_cnt), 32'(n_out[1]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
